cv32e40p_alu_health_mgr_ft: RTL and testbench
=============================================

// Module: cv32e40p_alu_health_mgr_ft
// PURPOSE
//  Downstream of the per-class ALU error counters in the fault-tolerant cv32e40p datapath.
//  Consumes "remove ALU replica r for op class c" requests and keeps a per-class health map
//  of the 3 redundant ALUs. For the op class now in decode it drives the replica enables and
//  the voter mode (TMR/DMR/SINGLE). It re-admits transiently removed replicas after a
//  probation period and makes a replica permanent-faulty after repeated strikes.
// PARAMETERS
//  N_CLASS          14    number of ALU op classes (normal, logic, shift ... pck)
//  N_ALU            3     redundant ALU replicas (fixed at 3; other values unsupported)
//  PROBATION_CYCLES 1024  cycles a removed replica stays out before re-admission
//  MAX_STRIKES      2     removals after which a replica is permanently faulty for that class
// PORTS
//  clk              in   1             clock
//  rst_n            in   1             reset, synchronous, active-low
//  remove_valid_i   in   1             removal request from error-counter stage
//  remove_ready_o   out  1             request accepted when valid&&ready
//  remove_alu_i     in   2             replica index 0..2
//  remove_class_i   in   4             op class index 0..N_CLASS-1
//  class_i          in   4             class of the op now in decode/EX
//  alu_en_o         out  3             replica enables for class_i
//  vote_mode_o      out  2             00 TMR, 01 DMR, 10 SINGLE, 11 reserved
//  fatal_o          out  1             sticky: some class had its last healthy replica hit
//  health_map_o     out  N_CLASS*3     1 = replica disabled (suspect or permanent), bit c*3+r
// BEHAVIOUR
//  Per entry (c,r): state HEALTHY/SUSPECT/PERMANENT plus a 2-bit saturating strike count.
//  Reset: all entries HEALTHY, strikes 0; fatal_o=0; health_map_o=0; FSM IDLE, timer 0.
//    remove_ready_o=1; alu_en_o=111; vote_mode_o=TMR.
//  alu_en_o/vote_mode_o: combinational from class_i and the registered map.
//    Mode: 3 enabled -> TMR; 2 enabled -> DMR; 1 enabled -> SINGLE.
//    class_i >= N_CLASS -> 111, TMR.
//  Accept (valid&&ready), with c<N_CLASS, r<3, entry not PERMANENT: strikes+=1 (saturating).
//    If the entry is the last enabled replica of class c: the entry stays enabled and
//      fatal_o is set (sticky until reset).
//    Else, if strikes reach MAX_STRIKES: entry -> PERMANENT.
//    Else: entry -> SUSPECT.
//    The update is visible on alu_en_o/health_map_o the cycle after acceptance.
//  Accept with c>=N_CLASS or r>=3, or an already-PERMANENT entry: consumed, no state change.
//  Probation FSM (single shared timer, TIMER_W=$clog2(PROBATION_CYCLES+1)):
//    IDLE:  any SUSPECT entry exists -> WAIT with timer=0.
//    WAIT:  timer++ each cycle.
//      timer==PROBATION_CYCLES-1 -> REINT.
//      A newly accepted removal restarts timer at 0 and stays in WAIT.
//    REINT: one cycle; lowest-index SUSPECT entry (c*3+r order) -> HEALTHY.
//      Its strikes are kept.
//      Then -> WAIT (timer=0) if other SUSPECT entries remain, else -> IDLE.
//      remove_ready_o=0 in REINT only. No request is lost; the producer holds valid.
//  Same-cycle remove and reintegration of the same entry cannot occur (ready=0 in REINT).
//  Reset mid-probation: everything returns to reset values, strikes included.
//  PERMANENT entries are never re-admitted; only rst_n clears them.
// STRUCTURE
//  Shared pkg (cv32e40p_pkg):
//    alu_class_e (4-bit enum, identical to the class grouping used by the error counters)
//    vote_mode_e
//    alu_health_e {HEALTHY, SUSPECT, PERMANENT}
//    N_ALU_CLASS=14 constant
//  Sub-module: cv32e40p_alu_probation_timer_ft
//    contents: IDLE/WAIT/REINT FSM + timer
//    inputs: any_suspect, restart
//    output: reint_pulse
//  Top module holds the health map, strike counters, priority encoder and mode decode.
// TESTING
//  1 Reset, class_i=0 -> alu_en_o=111, vote_mode_o=00, remove_ready_o=1, fatal_o=0.
//  2 remove(c=2,r=1), class_i=2 next cycle -> alu_en_o=101, DMR, health_map_o[7]=1.
//    class_i=3 -> 111, TMR.
//  3 After test 2, idle PROBATION_CYCLES(=16 in bench) cycles -> ready=0 for exactly 1 cycle.
//    Next cycle alu_en_o=111 for class 2.
//    Second remove(2,1) -> PERMANENT; 100 idle cycles -> still 101.
//  4 remove(5,0), then remove(5,2) -> class 5 SINGLE, alu_en_o=010.
//    remove(5,1) -> fatal_o=1, alu_en_o stays 010.
//  5 remove(c=14,r=0) and remove(c=0,r=3) -> handshakes complete, map unchanged.
//    remove held valid during REINT -> accepted the cycle after.
//  6 remove(1,0) at timer=10 of a wait started by remove(0,0) -> timer restarts.
//    Re-admission order: (0,0) first, then (1,0) one probation period later.
//    Assert rst_n=0 mid-wait -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/cv32e40p_pkg.sv
// Shared types for the fault-tolerant cv32e40p ALU datapath: op classes, voter modes,
// replica health states and the probation FSM encoding.
package cv32e40p_pkg;

  localparam int N_ALU_CLASS = 14;
  localparam int N_ALU       = 3;

  typedef enum logic [3:0] {
    CLS_NORMAL = 4'd0,  CLS_LOGIC  = 4'd1,  CLS_SHIFT  = 4'd2,  CLS_CMP    = 4'd3,
    CLS_ADD    = 4'd4,  CLS_SUB    = 4'd5,  CLS_MINMAX = 4'd6,  CLS_ABS    = 4'd7,
    CLS_BITCNT = 4'd8,  CLS_BITMAN = 4'd9,  CLS_SHUF   = 4'd10, CLS_CLIP   = 4'd11,
    CLS_DIV    = 4'd12, CLS_PCK    = 4'd13
  } alu_class_e;

  typedef enum logic [1:0] {
    VOTE_TMR    = 2'b00,
    VOTE_DMR    = 2'b01,
    VOTE_SINGLE = 2'b10,
    VOTE_RSVD   = 2'b11
  } vote_mode_e;

  typedef enum logic [1:0] {
    HEALTHY   = 2'd0,
    SUSPECT   = 2'd1,
    PERMANENT = 2'd2
  } alu_health_e;

  typedef enum logic [1:0] {
    PROB_IDLE  = 2'd0,
    PROB_WAIT  = 2'd1,
    PROB_REINT = 2'd2
  } prob_state_e;

endpackage

// File: rtl/cv32e40p_alu_health_mgr_ft_if.sv
// Removal-request handshake from the per-class ALU error counters.
interface cv32e40p_alu_health_mgr_ft_if;
  logic       remove_valid;
  logic       remove_ready;
  logic [1:0] remove_alu;
  logic [3:0] remove_class;

  modport master (output remove_valid, remove_alu, remove_class, input remove_ready);
  modport slave  (input remove_valid, remove_alu, remove_class, output remove_ready);
endinterface

// File: rtl/cv32e40p_alu_probation_timer_ft.sv
// Shared probation timer: waits PROBATION_CYCLES after the last removal, then emits a
// one-cycle reintegration pulse for the lowest-index suspect replica.
module cv32e40p_alu_probation_timer_ft
  import cv32e40p_pkg::*;
#(
  parameter int PROBATION_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic any_suspect,
  input  logic restart,
  output logic reint_pulse
);
  localparam int TIMER_W = $clog2(PROBATION_CYCLES + 1);
  localparam logic [TIMER_W-1:0] T_LAST = TIMER_W'(PROBATION_CYCLES - 1);

  prob_state_e state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PROB_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    reint_pulse = 1'b0;
    unique case (state_q)
      PROB_IDLE: if (any_suspect) begin
        state_d = PROB_WAIT;
        timer_d = '0;
      end
      PROB_WAIT: begin
        if (restart)               timer_d = '0;
        else if (timer_q == T_LAST) state_d = PROB_REINT;
        else                       timer_d = timer_q + TIMER_W'(1);
      end
      PROB_REINT: begin
        // any_suspect here already excludes the entry being re-admitted this cycle
        reint_pulse = 1'b1;
        timer_d     = '0;
        state_d     = any_suspect ? PROB_WAIT : PROB_IDLE;
      end
      default: state_d = PROB_IDLE;
    endcase
  end

endmodule

// File: rtl/cv32e40p_alu_health_mgr_ft.sv
// Per-class health map of the 3 redundant ALUs: applies removal requests, re-admits
// suspects after probation, and drives replica enables / voter mode for the decoded class.
module cv32e40p_alu_health_mgr_ft
  import cv32e40p_pkg::*;
#(
  parameter int N_CLASS          = N_ALU_CLASS,
  parameter int PROBATION_CYCLES = 1024,
  parameter int MAX_STRIKES      = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  cv32e40p_alu_health_mgr_ft_if.slave rm,
  input  logic [3:0]                class_i,
  output logic [2:0]                alu_en_o,
  output logic [1:0]                vote_mode_o,
  output logic                      fatal_o,
  output logic [N_CLASS*N_ALU-1:0]  health_map_o
);
  localparam int N_ENT = N_CLASS * N_ALU;

  alu_health_e      state_q   [N_ENT];
  logic [1:0]       strikes_q [N_ENT];
  logic             fatal_q;
  logic [N_ENT-1:0] suspect_vec, dis_vec, reint_oh;
  logic             reint_pulse, any_suspect, accept, req_ok, upd, last_en, cls_ok;
  logic [2:0]       rm_en;
  logic [1:0]       str_nxt;
  int               rm_base, rm_idx, cls_base;

  always_comb begin
    for (int i = 0; i < N_ENT; i++) begin
      suspect_vec[i] = (state_q[i] == SUSPECT);
      dis_vec[i]     = (state_q[i] != HEALTHY);
    end
  end

  // isolate lowest set bit: c*3+r ordering gives the re-admission priority
  assign reint_oh    = suspect_vec & (~suspect_vec + N_ENT'(1));
  assign any_suspect = reint_pulse ? |(suspect_vec & ~reint_oh) : |suspect_vec;

  assign rm.remove_ready = ~reint_pulse;
  assign accept          = rm.remove_valid & rm.remove_ready;
  assign req_ok          = (int'(rm.remove_class) < N_CLASS) && (rm.remove_alu < 2'd3);

  always_comb begin
    rm_base = 0;
    rm_idx  = 0;
    rm_en   = 3'b000;
    if (req_ok) begin
      rm_base = int'(rm.remove_class) * N_ALU;
      rm_idx  = rm_base + int'(rm.remove_alu);
      for (int r = 0; r < N_ALU; r++) rm_en[r] = ~dis_vec[rm_base + r];
    end
  end

  assign upd     = accept && req_ok && (state_q[rm_idx] != PERMANENT);
  assign last_en = (rm_en == (3'b001 << rm.remove_alu));
  assign str_nxt = (strikes_q[rm_idx] == 2'd3) ? 2'd3 : strikes_q[rm_idx] + 2'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENT; i++) begin
        state_q[i]   <= HEALTHY;
        strikes_q[i] <= 2'd0;
      end
      fatal_q <= 1'b0;
    end else begin
      // reint and upd are exclusive: ready is low during the reintegration cycle
      if (reint_pulse) begin
        for (int i = 0; i < N_ENT; i++)
          if (reint_oh[i]) state_q[i] <= HEALTHY;
      end
      if (upd) begin
        strikes_q[rm_idx] <= str_nxt;
        if (last_en)                         fatal_q         <= 1'b1;
        else if (int'(str_nxt) >= MAX_STRIKES) state_q[rm_idx] <= PERMANENT;
        else                                 state_q[rm_idx] <= SUSPECT;
      end
    end
  end

  cv32e40p_alu_probation_timer_ft #(
    .PROBATION_CYCLES(PROBATION_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .any_suspect(any_suspect),
    .restart    (upd),
    .reint_pulse(reint_pulse)
  );

  assign cls_ok = int'(class_i) < N_CLASS;

  always_comb begin
    cls_base = cls_ok ? int'(class_i) * N_ALU : 0;
    alu_en_o = 3'b111;
    if (cls_ok)
      for (int r = 0; r < N_ALU; r++) alu_en_o[r] = ~dis_vec[cls_base + r];
    unique case (alu_en_o)
      3'b111:                 vote_mode_o = VOTE_TMR;
      3'b011, 3'b101, 3'b110: vote_mode_o = VOTE_DMR;
      default:                vote_mode_o = VOTE_SINGLE;
    endcase
  end

  assign fatal_o      = fatal_q;
  assign health_map_o = dis_vec;

endmodule

// File: tb/tb_cv32e40p_alu_health_mgr_ft.sv
// Directed bench for the ALU health manager with a short probation period (16 cycles).
module tb_cv32e40p_alu_health_mgr_ft;
  localparam int NC = 14;
  localparam int PC = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    class_i;
  logic [2:0]    alu_en;
  logic [1:0]    vote_mode;
  logic          fatal;
  logic [NC*3-1:0] hmap;
  int            n_chk = 0;
  int            n_bad = 0;
  int            w;

  cv32e40p_alu_health_mgr_ft_if rif ();

  cv32e40p_alu_health_mgr_ft #(
    .N_CLASS(NC), .PROBATION_CYCLES(PC), .MAX_STRIKES(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rm          (rif),
    .class_i     (class_i),
    .alu_en_o    (alu_en),
    .vote_mode_o (vote_mode),
    .fatal_o     (fatal),
    .health_map_o(hmap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic do_rm(input int c, input int r);
    bit ok = 1'b0;
    rif.remove_valid = 1'b1;
    rif.remove_class = 4'(c);
    rif.remove_alu   = 2'(r);
    for (int k = 0; k < 60 && !ok; k++) begin
      ok = rif.remove_ready;
      @(negedge clk);
    end
    rif.remove_valid = 1'b0;
    if (!ok) chk("rm_timeout", 0, 1);
  endtask

  task automatic wait_rdy_low(output int cnt);
    cnt = 0;
    while (rif.remove_ready && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_en"},    alu_en, 3'b111);
    chk({tag, "_mode"},  vote_mode, 2'b00);
    chk({tag, "_rdy"},   rif.remove_ready, 1'b1);
    chk({tag, "_fatal"}, fatal, 1'b0);
    chk({tag, "_map"},   hmap, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    class_i = 4'd0;
    rif.remove_valid = 1'b0;
    rif.remove_class = 4'd0;
    rif.remove_alu   = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("t1");

    // single removal -> DMR for that class only
    do_rm(2, 1);
    class_i = 4'd2; #1;
    chk("t2_en", alu_en, 3'b101);
    chk("t2_mode", vote_mode, 2'b01);
    chk("t2_map", hmap, 42'h80);
    class_i = 4'd3; #1;
    chk("t2_other_en", alu_en, 3'b111);
    chk("t2_other_mode", vote_mode, 2'b00);

    // probation: REINT after 17 cycles, ready low for exactly one cycle
    class_i = 4'd2;
    wait_rdy_low(w);
    chk("t3_wait", w, 17);
    chk("t3_rdy_low", rif.remove_ready, 1'b0);
    @(negedge clk);
    chk("t3_rdy_back", rif.remove_ready, 1'b1);
    chk("t3_readmit", alu_en, 3'b111);
    chk("t3_map0", hmap, '0);
    do_rm(2, 1);
    chk("t3_perm_en", alu_en, 3'b101);
    repeat (100) @(negedge clk);
    chk("t3_perm_hold", alu_en, 3'b101);
    chk("t3_perm_mode", vote_mode, 2'b01);
    chk("t3_no_reint", rif.remove_ready, 1'b1);

    // class 5 down to one replica, then the last one is hit
    class_i = 4'd5;
    do_rm(5, 0);
    do_rm(5, 2); #1;
    chk("t4_single_en", alu_en, 3'b010);
    chk("t4_single_mode", vote_mode, 2'b10);
    chk("t4_fatal0", fatal, 1'b0);
    do_rm(5, 1);
    chk("t4_fatal", fatal, 1'b1);
    chk("t4_last_en", alu_en, 3'b010);
    chk("t4_map", hmap, 42'h80 | (42'd1 << 15) | (42'd1 << 17));

    // out-of-range requests are consumed without effect
    do_rm(14, 0);
    chk("t5_bad_cls", hmap, 42'h80 | (42'd1 << 15) | (42'd1 << 17));
    do_rm(0, 3);
    chk("t5_bad_alu", hmap, 42'h80 | (42'd1 << 15) | (42'd1 << 17));
    class_i = 4'd14; #1;
    chk("t5_cls_oor_en", alu_en, 3'b111);
    class_i = 4'd5;

    // request held through REINT is taken the following cycle
    wait_rdy_low(w);
    chk("t5_reint_seen", rif.remove_ready, 1'b0);
    rif.remove_valid = 1'b1;
    rif.remove_class = 4'd3;
    rif.remove_alu   = 2'd0;
    @(negedge clk);
    chk("t5_held_pend", hmap[9], 1'b0);
    chk("t5_rdy_after", rif.remove_ready, 1'b1);
    @(negedge clk);
    rif.remove_valid = 1'b0;
    chk("t5_held_acc", hmap[9], 1'b1);
    chk("t5_cls5_en", alu_en, 3'b011);
    chk("t5_map", hmap, 42'h80 | (42'd1 << 17) | (42'd1 << 9));

    // reset with suspects pending and fatal set
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("t6_rst_a");
    rst_n = 1'b1;
    @(negedge clk);

    // restart of the shared timer; lowest index re-admitted first
    class_i = 4'd0;
    do_rm(0, 0);
    repeat (11) @(negedge clk);
    do_rm(1, 0);
    wait_rdy_low(w);
    chk("t6_restart_wait", w, 16);
    chk("t6_both_out", hmap, 42'h9);
    @(negedge clk);
    chk("t6_first_00", hmap, 42'h8);
    wait_rdy_low(w);
    chk("t6_second_wait", w, 16);
    @(negedge clk);
    chk("t6_second_10", hmap, '0);

    // reset mid-wait
    class_i = 4'd4;
    do_rm(4, 1);
    repeat (5) @(negedge clk);
    chk("t6_pre_rst_en", alu_en, 3'b101);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("t6_rst_b");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_post_map", hmap, '0);
    chk("t6_post_rdy", rif.remove_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
